// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit sequencing fetch (T0-T2) and execute (T3-T6).
// Define CTRL_MEM_TIMEOUT_EN to bound the T1 memory wait to MEM_TIMEOUT cycles (FAULT on expiry).
module control_sequencer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [15:0] R0_15_enable,
    output logic [15:0] R0_15_out,
    output logic [7:0]  ld_en,
    output logic [5:0]  drv_out,
    output logic        Read,
    output logic        IncPC,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        fault
);

    localparam logic [3:0] S_T0    = 4'd0;
    localparam logic [3:0] S_T1    = 4'd1;
    localparam logic [3:0] S_T2    = 4'd2;
    localparam logic [3:0] S_T3    = 4'd3;
    localparam logic [3:0] S_T4    = 4'd4;
    localparam logic [3:0] S_T5    = 4'd5;
    localparam logic [3:0] S_T6    = 4'd6;
    localparam logic [3:0] S_HALT  = 4'd7;
    localparam logic [3:0] S_FAULT = 4'd8;

    localparam logic [7:0] LD_PC  = 8'h80;
    localparam logic [7:0] LD_IR  = 8'h40;
    localparam logic [7:0] LD_MAR = 8'h20;
    localparam logic [7:0] LD_MDR = 8'h10;
    localparam logic [7:0] LD_Y   = 8'h08;
    localparam logic [7:0] LD_Z   = 8'h04;
    localparam logic [7:0] LD_HI  = 8'h02;
    localparam logic [7:0] LD_LO  = 8'h01;

    localparam logic [5:0] DRV_PC  = 6'h20;
    localparam logic [5:0] DRV_MDR = 6'h10;
    localparam logic [5:0] DRV_ZLO = 6'h08;
    localparam logic [5:0] DRV_ZHI = 6'h04;

    logic [3:0]  r_state;
    logic [3:0]  w_nextState;
    logic        r_isHiLo;
    logic [4:0]  w_op;
    logic        w_aluClass;
    logic        w_hiLoClass;
    logic [15:0] w_raBit;
    logic [15:0] w_rbBit;
    logic [15:0] w_rcBit;
    logic        w_timeout;
    logic        w_unused;

    assign w_op        = IR[31:27];
    assign w_aluClass  = (w_op <= 5'd14);
    assign w_hiLoClass = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_raBit     = 16'h8000 >> IR[26:23];
    assign w_rbBit     = 16'h8000 >> IR[22:19];
    assign w_rcBit     = 16'h8000 >> IR[18:15];
    assign w_unused    = ^{IR[14:0], (MEM_TIMEOUT > 0)};

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_waitCnt;

    // w_timeout marks the last permitted T1 cycle; mem_ready on that cycle still wins.
    assign w_timeout = (r_waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_waitCnt <= '0;
        end else if ((r_state == S_T1) && !mem_ready && !w_timeout) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_T0;
            r_isHiLo <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_T3) begin
                r_isHiLo <= w_hiLoClass;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_T0: w_nextState = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    w_nextState = S_T2;
                end else if (w_timeout) begin
                    w_nextState = S_FAULT;
                end
            end
            S_T2: w_nextState = S_T3;
            S_T3: begin
                if (w_aluClass || w_hiLoClass) begin
                    w_nextState = S_T4;
                end else if (w_op == 5'd26) begin
                    w_nextState = S_T0;
                end else if (w_op == 5'd27) begin
                    w_nextState = S_HALT;
                end else begin
                    w_nextState = S_FAULT;
                end
            end
            S_T4:   w_nextState = S_T5;
            S_T5:   w_nextState = r_isHiLo ? S_T6 : S_T0;
            S_T6:   w_nextState = S_T0;
            S_HALT: w_nextState = S_HALT;
            default: w_nextState = S_FAULT;
        endcase
    end

    // clr gates every output so an asynchronous clear silences strobes without waiting for a clock.
    always_comb begin
        R0_15_enable = '0;
        R0_15_out    = '0;
        ld_en        = '0;
        drv_out      = '0;
        Read         = 1'b0;
        IncPC        = 1'b0;
        opcode       = '0;
        run          = 1'b0;
        fault        = 1'b0;
        if (!clr) begin
            case (r_state)
                S_T0: begin
                    run     = 1'b1;
                    drv_out = DRV_PC;
                    ld_en   = LD_MAR | LD_Z;
                    IncPC   = 1'b1;
                end
                S_T1: begin
                    run     = 1'b1;
                    drv_out = DRV_ZLO;
                    ld_en   = LD_PC | LD_MDR;
                    Read    = 1'b1;
                end
                S_T2: begin
                    run     = 1'b1;
                    drv_out = DRV_MDR;
                    ld_en   = LD_IR;
                end
                S_T3: begin
                    run = 1'b1;
                    if (w_aluClass || w_hiLoClass) begin
                        R0_15_out = w_rbBit;
                        ld_en     = LD_Y;
                    end
                end
                S_T4: begin
                    run       = 1'b1;
                    R0_15_out = w_rcBit;
                    opcode    = w_op;
                    ld_en     = LD_Z;
                end
                S_T5: begin
                    run     = 1'b1;
                    drv_out = DRV_ZLO;
                    if (r_isHiLo) begin
                        ld_en = LD_LO;
                    end else begin
                        R0_15_enable = w_raBit;
                    end
                end
                S_T6: begin
                    run     = 1'b1;
                    drv_out = DRV_ZHI;
                    ld_en   = LD_HI;
                end
                S_HALT: begin
                    run = 1'b0;
                end
                default: begin
                    fault = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: applyStimulus queues per-cycle expected strobe vectors,
// checkOutput pops and compares them. Timeout scenarios run only when CTRL_MEM_TIMEOUT_EN is defined.
module tb_control_sequencer;
    localparam int MEM_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] R0_15_enable;
    logic [15:0] R0_15_out;
    logic [7:0]  ld_en;
    logic [5:0]  drv_out;
    logic        Read;
    logic        IncPC;
    logic [4:0]  opcode;
    logic        run;
    logic        fault;
    logic [54:0] obsVec;

    int          errors = 0;
    int          checks = 0;
    logic [54:0] expQ[$];
    logic        mrQ[$];
    string       tagQ[$];

    control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .clr          (clr),
        .IR           (IR),
        .mem_ready    (mem_ready),
        .R0_15_enable (R0_15_enable),
        .R0_15_out    (R0_15_out),
        .ld_en        (ld_en),
        .drv_out      (drv_out),
        .Read         (Read),
        .IncPC        (IncPC),
        .opcode       (opcode),
        .run          (run),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    assign obsVec = {run, fault, Read, IncPC, opcode, ld_en, drv_out, R0_15_out, R0_15_enable};

    function automatic logic [54:0] mkVec(input logic runV, input logic faultV, input logic readV,
                                          input logic incV, input logic [4:0] opc, input logic [7:0] ld,
                                          input logic [5:0] drv, input logic [15:0] rout,
                                          input logic [15:0] ren);
        return {runV, faultV, readV, incV, opc, ld, drv, rout, ren};
    endfunction

    function automatic logic [15:0] regBit(input logic [3:0] n);
        return 16'h8000 >> n;
    endfunction

    function automatic logic [31:0] mkIR(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        logic [14:0] junk;
        junk = 15'($urandom);
        return {op, ra, rb, rc, junk};
    endfunction

    function automatic logic [54:0] vecT0();
        return mkVec(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h24, 6'h20, 16'h0, 16'h0);
    endfunction

    function automatic logic [54:0] vecT1();
        return mkVec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h90, 6'h08, 16'h0, 16'h0);
    endfunction

    function automatic logic [54:0] vecT2();
        return mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h40, 6'h10, 16'h0, 16'h0);
    endfunction

    function automatic logic [54:0] vecIdle(input logic runV, input logic faultV);
        return mkVec(runV, faultV, 1'b0, 1'b0, 5'd0, 8'h00, 6'h00, 16'h0, 16'h0);
    endfunction

    task automatic pushEntry(input string tag, input logic [54:0] vec, input logic mr);
        tagQ.push_back(tag);
        expQ.push_back(vec);
        mrQ.push_back(mr);
    endtask

    task automatic checkOutput();
        logic [54:0] expVec;
        string       tag;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard: observed=%h required=<empty queue>", obsVec);
        end else begin
            expVec = expQ.pop_front();
            tag    = tagQ.pop_front();
            void'(mrQ.pop_front());
            assert (obsVec === expVec) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%h required=%h", tag, obsVec, expVec);
            end
        end
    endtask

    task automatic runQueue(input int maxEntries);
        for (int k = 0; k < maxEntries && expQ.size() > 0; k++) begin
            mem_ready = mrQ[0];
            #1;
            checkOutput();
            @(negedge clk);
        end
    endtask

    task automatic flushQueue();
        expQ.delete();
        mrQ.delete();
        tagQ.delete();
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input int waits, input string name);
        logic [4:0] op;
        op = ir[31:27];
        IR = ir;
        pushEntry({name, ".T0"}, vecT0(), 1'b0);
        for (int i = 0; i < waits; i++) begin
            pushEntry({name, ".T1wait"}, vecT1(), 1'b0);
        end
        pushEntry({name, ".T1"}, vecT1(), 1'b1);
        pushEntry({name, ".T2"}, vecT2(), 1'b0);
        if (op <= 5'd16) begin
            pushEntry({name, ".T3"}, mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h08, 6'h00,
                                           regBit(ir[22:19]), 16'h0), 1'b0);
            pushEntry({name, ".T4"}, mkVec(1'b1, 1'b0, 1'b0, 1'b0, op, 8'h04, 6'h00,
                                           regBit(ir[18:15]), 16'h0), 1'b0);
            if (op <= 5'd14) begin
                pushEntry({name, ".T5"}, mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 6'h08,
                                               16'h0, regBit(ir[26:23])), 1'b0);
            end else begin
                pushEntry({name, ".T5"}, mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h01, 6'h08,
                                               16'h0, 16'h0), 1'b0);
                pushEntry({name, ".T6"}, mkVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h02, 6'h04,
                                               16'h0, 16'h0), 1'b0);
            end
        end else begin
            pushEntry({name, ".T3"}, vecIdle(1'b1, 1'b0), 1'b0);
            if (op == 5'd27) begin
                for (int i = 0; i < 3; i++) pushEntry({name, ".halt"}, vecIdle(1'b0, 1'b0), 1'b1);
            end else if (op != 5'd26) begin
                for (int i = 0; i < 3; i++) pushEntry({name, ".fault"}, vecIdle(1'b0, 1'b1), 1'b1);
            end
        end
    endtask

    // Entered at a negedge; holds clr across one rising edge and releases it on a later negedge.
    task automatic doReset(input string name);
        clr = 1'b1;
        #1;
        pushEntry({name, ".hold"}, vecIdle(1'b0, 1'b0), 1'b0);
        checkOutput();
        @(negedge clk);
        #1;
        pushEntry({name, ".afterEdge"}, vecIdle(1'b0, 1'b0), 1'b0);
        checkOutput();
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr       = 1'b1;
        IR        = 32'h0;
        mem_ready = 1'b0;
        @(negedge clk);
        doReset("reset");

        applyStimulus(mkIR(5'd3, 4'd1, 4'd2, 4'd3), 0, "add");
        runQueue(1000);
        applyStimulus(mkIR(5'd0, 4'd15, 4'd0, 4'd15), 0, "op0");
        runQueue(1000);
        applyStimulus(mkIR(5'd14, 4'd7, 4'd7, 4'd7), 0, "op14");
        runQueue(1000);
        applyStimulus(mkIR(5'd15, 4'd2, 4'd4, 4'd5), 0, "mul");
        runQueue(1000);
        applyStimulus(mkIR(5'd16, 4'd9, 4'd10, 4'd11), 1, "div");
        runQueue(1000);
        applyStimulus(mkIR(5'd3, 4'd4, 4'd5, 4'd6), 3, "wait3");
        runQueue(1000);
        applyStimulus(mkIR(5'd26, 4'd0, 4'd0, 4'd0), 0, "nop");
        runQueue(1000);

`ifdef CTRL_MEM_TIMEOUT_EN
        applyStimulus(mkIR(5'd1, 4'd8, 4'd9, 4'd10), MEM_TIMEOUT - 1, "lastChance");
        runQueue(1000);
        IR = mkIR(5'd3, 4'd1, 4'd2, 4'd3);
        pushEntry("timeout.T0", vecT0(), 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) pushEntry("timeout.T1", vecT1(), 1'b0);
        for (int i = 0; i < 3; i++) pushEntry("timeout.fault", vecIdle(1'b0, 1'b1), 1'b1);
        runQueue(1000);
        doReset("timeoutClr");
`else
        applyStimulus(mkIR(5'd2, 4'd12, 4'd13, 4'd14), 12, "longWait");
        runQueue(1000);
`endif

        $display("[TB] clearing asynchronously during T4");
        applyStimulus(mkIR(5'd5, 4'd3, 4'd6, 4'd9), 0, "abort");
        runQueue(4);
        mem_ready = mrQ[0];
        #1;
        checkOutput();
        flushQueue();
        #1;
        clr = 1'b1;
        #1;
        pushEntry("abort.asyncClr", vecIdle(1'b0, 1'b0), 1'b0);
        checkOutput();
        @(negedge clk);
        #1;
        pushEntry("abort.noRaLoad", vecIdle(1'b0, 1'b0), 1'b0);
        checkOutput();
        @(negedge clk);
        clr = 1'b0;

        applyStimulus(mkIR(5'd17, 4'd1, 4'd1, 4'd1), 0, "badOp17");
        runQueue(1000);
        doReset("clr17");
        applyStimulus(mkIR(5'd31, 4'd1, 4'd1, 4'd1), 0, "badOp31");
        runQueue(1000);
        doReset("clr31");
        applyStimulus(mkIR(5'd27, 4'd1, 4'd1, 4'd1), 0, "halt");
        runQueue(1000);
        doReset("clrHalt");

        applyStimulus(mkIR(5'd7, 4'd0, 4'd15, 4'd8), 0, "recover");
        runQueue(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
